fts_pulse_scheduler: RTL and testbench

//  Fast-domain (clk1) scheduler sharing one fast-to-slow single-bit pulse channel among N_REQ requesters.

---
 rtl/fts_pulse_scheduler_if.sv | 38 +++
 rtl/fts_pulse_scheduler.sv | 154 +++++++++++++++
 tb/tb_fts_pulse_scheduler.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fts_pulse_scheduler_if.sv
// Signal bundle between fts_pulse_scheduler (slave) and its requesters / slow-side logic (master).
// FTS_SCHED_ACK_EN adds ack_sync, the clk2 acknowledge already synchronized into clk1.
interface fts_pulse_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] pend;
    logic             chan_pulse;
    logic [ID_W-1:0]  chan_id;
    logic             grant_vld;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;
    logic [2:0]       fsm_state;

    // Handshake: req is a fire-and-forget pulse (no ready); a pulse hitting an already-set
    // pend bit is counted in drop_cnt. With the ack option, chan_pulse/ack_sync run a
    // four-phase handshake: pulse up, ack up, pulse down, ack down.
`ifdef FTS_SCHED_ACK_EN
    logic ack_sync;

    modport master (output req, output ack_sync,
                    input pend, input chan_pulse, input chan_id, input grant_vld,
                    input busy, input drop_cnt, input fsm_state);
    modport slave  (input req, input ack_sync,
                    output pend, output chan_pulse, output chan_id, output grant_vld,
                    output busy, output drop_cnt, output fsm_state);
`else
    modport master (output req,
                    input pend, input chan_pulse, input chan_id, input grant_vld,
                    input busy, input drop_cnt, input fsm_state);
    modport slave  (input req,
                    output pend, output chan_pulse, output chan_id, output grant_vld,
                    output busy, output drop_cnt, output fsm_state);
`endif
endinterface

// File: rtl/fts_pulse_scheduler.sv
// Round-robin scheduler sharing one fast-to-slow pulse channel among N_REQ requesters.
// Optional macro FTS_SCHED_ACK_EN: hold the pulse until a four-phase ack from the slow side.
module fts_pulse_scheduler #(
    parameter int N_REQ     = 4,
    parameter int PULSE_CYC = 3,
    parameter int GAP_CYC   = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 clk1,
    input  logic                 sys_rst,
    fts_pulse_scheduler_if.slave bus
);
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SUM_W   = CNT_W + 5;

    localparam logic [CW-1:0]    PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]    GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [SUM_W-1:0] SAT      = {5'b0, {CNT_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE   = 3'd1,
`ifdef FTS_SCHED_ACK_EN
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4,
`endif
        GAP     = 3'd2
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_REQ-1:0] pend_q, pend_n, clr, drops;
    logic             chan_pulse_q, pulse_n;
    logic [ID_W-1:0]  chan_id_q, id_n;
    logic             grant_vld_q, grant;
    logic [CNT_W-1:0] drop_cnt_q, drop_n;
    logic [ID_W-1:0]  rr_last, winner;
    logic [SUM_W-1:0] ndrop, sum;

    // Round-robin search: first pending bit at or after rr_last+1, wrapping at N_REQ-1.
    always_comb begin
        int              pos;
        logic [ID_W-1:0] idx;
        logic            found;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(rr_last) + 1 + k) % N_REQ;
            idx = ID_W'(pos);
            if (!found && pend_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse_n = chan_pulse_q;
        id_n    = chan_id_q;
        grant   = 1'b0;
        case (state)
            IDLE: begin
                if (|pend_q) grant = 1'b1;
            end
            PULSE: begin
                if (cnt == '0) begin
`ifdef FTS_SCHED_ACK_EN
                    state_n = WAIT_HI;
`else
                    state_n = GAP;
                    pulse_n = 1'b0;
                    cnt_n   = GAP_LD;
`endif
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt != '0)   cnt_n   = cnt - 1'b1;
                else if (|pend_q) grant  = 1'b1;
                else             state_n = IDLE;
            end
`ifdef FTS_SCHED_ACK_EN
            WAIT_HI: begin
                if (bus.ack_sync) begin
                    pulse_n = 1'b0;
                    state_n = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.ack_sync) begin
                    cnt_n   = GAP_LD;
                    state_n = GAP;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        if (grant) begin
            state_n = PULSE;
            pulse_n = 1'b1;
            id_n    = winner;
            cnt_n   = PULSE_LD;
        end
    end

    // A request colliding with its own grant re-arms pend and is not a drop.
    always_comb begin
        clr = '0;
        if (grant) clr[winner] = 1'b1;
        drops  = bus.req & pend_q & ~clr;
        pend_n = (pend_q & ~clr) | bus.req;
        ndrop  = '0;
        for (int i = 0; i < N_REQ; i++) ndrop = ndrop + SUM_W'(drops[i]);
        sum    = {5'b0, drop_cnt_q} + ndrop;
        drop_n = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk1 or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pend_q       <= '0;
            chan_pulse_q <= 1'b0;
            chan_id_q    <= '0;
            grant_vld_q  <= 1'b0;
            drop_cnt_q   <= '0;
            rr_last      <= ID_W'(N_REQ - 1);
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pend_q       <= pend_n;
            chan_pulse_q <= pulse_n;
            chan_id_q    <= id_n;
            grant_vld_q  <= grant;
            drop_cnt_q   <= drop_n;
            if (grant) rr_last <= winner;
        end
    end

    assign bus.pend       = pend_q;
    assign bus.chan_pulse = chan_pulse_q;
    assign bus.chan_id    = chan_id_q;
    assign bus.grant_vld  = grant_vld_q;
    assign bus.busy       = (state != IDLE);
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_fts_pulse_scheduler.sv
// Bench for fts_pulse_scheduler: per-cycle comparison against a grant-slot reference model,
// plus scenario checks (reset, fairness, drops, collision, mid-pulse reset, ack option).
module tb_fts_pulse_scheduler;
    localparam int N_REQ     = 4;
    localparam int PULSE_CYC = 3;
    localparam int GAP_CYC   = 3;
    localparam int CNT_W     = 8;
    localparam int ID_W      = 2;
    localparam int PERIOD    = PULSE_CYC + GAP_CYC;
    localparam int OBS_W     = N_REQ + 1 + ID_W + 1 + 1 + CNT_W;
    localparam int DROP_MAX  = (1 << CNT_W) - 1;

    logic clk1    = 1'b0;
    logic sys_rst = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    fts_pulse_scheduler_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus ();

    fts_pulse_scheduler #(
        .N_REQ(N_REQ), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk1(clk1),
        .sys_rst(sys_rst),
        .bus(bus.slave)
    );

    always #5 clk1 = ~clk1;

    // Reference model: a grant may start at edge e when something is pending and at least
    // PERIOD edges have passed since the previous grant; the pulse occupies the first
    // PULSE_CYC cycles of that slot and busy covers the whole slot.
    logic [N_REQ-1:0] m_pend = '0;
    int               m_drop = 0;
    int               m_rr   = N_REQ - 1;
    int               m_id   = 0;
    int               m_g    = -100;
    int               m_next = 0;
    int               e_now  = 0;
    logic [ID_W-1:0]  exp_q[$];
    logic [ID_W-1:0]  got_q[$];
    int               got_t[$];

    task automatic model_step();
        logic [N_REQ-1:0] clr;
        int               w;
        int               n;
        if (sys_rst) begin
            m_pend = '0;
            m_drop = 0;
            m_rr   = N_REQ - 1;
            m_id   = 0;
            m_g    = -100;
            m_next = 0;
        end else begin
            e_now = e_now + 1;
            clr   = '0;
            w     = 0;
            if (m_pend != '0 && e_now >= m_next) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    w = (m_rr + k) % N_REQ;
                    if (m_pend[w]) break;
                end
                clr[w] = 1'b1;
                m_rr   = w;
                m_id   = w;
                m_g    = e_now;
                m_next = e_now + PERIOD;
                exp_q.push_back(ID_W'(w));
            end
            n = 0;
            for (int i = 0; i < N_REQ; i++) if (bus.req[i] && m_pend[i] && !clr[i]) n++;
            m_drop = (m_drop + n > DROP_MAX) ? DROP_MAX : m_drop + n;
            m_pend = (m_pend & ~clr) | bus.req;
        end
    endtask

    always @(posedge clk1 or posedge sys_rst) model_step();

    always @(negedge clk1) begin
        if (!sys_rst && bus.grant_vld) begin
            got_q.push_back(bus.chan_id);
            got_t.push_back(e_now);
        end
    end

    function automatic logic [OBS_W-1:0] exp_vec();
        logic pulse, gv, bsy;
        pulse = (e_now >= m_g) && (e_now < m_g + PULSE_CYC);
        gv    = (e_now == m_g);
        bsy   = (e_now >= m_g) && (e_now < m_g + PERIOD);
        return {m_pend, pulse, ID_W'(m_id), gv, bsy, CNT_W'(m_drop)};
    endfunction

    function automatic logic [OBS_W-1:0] obs_vec();
        return {bus.pend, bus.chan_pulse, bus.chan_id, bus.grant_vld, bus.busy, bus.drop_cnt};
    endfunction

    function automatic bit queues_match();
        if (exp_q.size() != got_q.size()) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i] !== got_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int count_id(input int id);
        int n = 0;
        foreach (got_q[i]) if (int'(got_q[i]) == id) n++;
        return n;
    endfunction

    task automatic apply_reset();
        @(negedge clk1);
        sys_rst = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk1);
        sys_rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

`ifndef FTS_SCHED_ACK_EN
    task automatic test_reset();
        int hi_cnt, gv_cnt, first_hi;
        sys_rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk1);
            checks++;
            if (obs_vec() !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=0", c, obs_vec());
            end
            bus.req = N_REQ'($urandom_range(0, 15));
        end
        @(negedge clk1);
        sys_rst = 1'b0;
        bus.req = '0;
        exp_q.delete(); got_q.delete(); got_t.delete();
        @(negedge clk1);
        bus.req  = 4'b0001;
        hi_cnt   = 0;
        gv_cnt   = 0;
        first_hi = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk1);
            bus.req = '0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_first cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (bus.chan_pulse) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
            end
            if (bus.grant_vld) gv_cnt++;
        end
        checks++;
        if (first_hi != 1 || hi_cnt != PULSE_CYC || gv_cnt != 1) begin
            errors++;
            $display("FAIL reset_pulse_shape got first=%0d hi=%0d gv=%0d exp 1/%0d/1",
                     first_hi, hi_cnt, gv_cnt, PULSE_CYC);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.chan_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_end got busy=%b id=%0d exp busy=0 id=0", bus.busy, bus.chan_id);
        end
    endtask

    task automatic test_fairness();
        int ord_a[4] = '{0, 1, 2, 3};
        int ord_b[5] = '{1, 2, 3, 0, 1};
        apply_reset();
        @(negedge clk1);
        bus.req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk1);
            bus.req = '0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fair_a cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL fair_a_count got=%0d exp=4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (int'(got_q[i]) != ord_a[i]) begin
                    errors++;
                    $display("FAIL fair_a_order[%0d] got=%0d exp=%0d", i, got_q[i], ord_a[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_t[i] - got_t[i-1] != PERIOD) begin
                        errors++;
                        $display("FAIL fair_a_spacing[%0d] got=%0d exp=%0d", i,
                                 got_t[i] - got_t[i-1], PERIOD);
                    end
                end
            end
        end
        checks++;
        if (bus.pend !== '0) begin
            errors++;
            $display("FAIL fair_a_pend got=%b exp=0000", bus.pend);
        end
        got_q.delete(); got_t.delete(); exp_q.delete();
        // grant id 1 alone so the next round starts searching at 2
        @(negedge clk1);
        bus.req = 4'b0010;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk1);
            bus.req = (c == 11) ? 4'b1111 : 4'b0000;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fair_b cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL fair_b_count got=%0d exp=5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (int'(got_q[i]) != ord_b[i]) begin
                    errors++;
                    $display("FAIL fair_b_order[%0d] got=%0d exp=%0d", i, got_q[i], ord_b[i]);
                end
            end
        end
    endtask

    task automatic test_drop();
        logic [N_REQ-1:0] seq[7] = '{4'b0001, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            bus.req = (c < 7) ? seq[c] : 4'b0000;
        end
        checks++;
        if (bus.drop_cnt !== 8'd2 || count_id(2) != 1) begin
            errors++;
            $display("FAIL drop_count got drop=%0d id2_grants=%0d exp drop=2 id2_grants=1",
                     bus.drop_cnt, count_id(2));
        end
        checks++;
        if (!queues_match()) begin
            errors++;
            $display("FAIL drop_grants got=%0d exp=%0d grants", got_q.size(), exp_q.size());
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_sat cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            bus.req = (c < 380) ? 4'b1000 : 4'b0000;
        end
        checks++;
        if (bus.drop_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL drop_saturate got=%0d exp=255", bus.drop_cnt);
        end
    endtask

    task automatic test_collision();
        apply_reset();
        @(negedge clk1);
        bus.req = 4'b0010;
        @(negedge clk1);
        bus.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk1);
            bus.req = '0;
            if (c == 0) begin
                checks++;
                if (bus.pend !== 4'b0010 || bus.drop_cnt !== 8'd0 || bus.grant_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL collide_edge got pend=%b drop=%0d gv=%b exp 0010/0/1",
                             bus.pend, bus.drop_cnt, bus.grant_vld);
                end
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL collide cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (count_id(1) != 2 || bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL collide_grants got id1=%0d drop=%0d exp id1=2 drop=0",
                     count_id(1), bus.drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit seen;
        apply_reset();
        @(negedge clk1);
        bus.req = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk1);
            bus.req = '0;
            seen = bus.chan_pulse;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_wait got no pulse within 10 cycles exp pulse");
        end
        bus.req = 4'b1001;
        @(negedge clk1);
        bus.req = '0;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_pre got=%h exp=%h", obs_vec(), exp_vec());
        end
        #1 sys_rst = 1'b1;
        #1;
        checks++;
        if (bus.chan_pulse !== 1'b0 || bus.pend !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async got pulse=%b pend=%b busy=%b exp 0/0000/0",
                     bus.chan_pulse, bus.pend, bus.busy);
        end
        @(negedge clk1);
        @(negedge clk1);
        sys_rst = 1'b0;
        base    = got_q.size();
        bus.req = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk1);
            bus.req = '0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (got_q.size() <= base || got_q[base] !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_first got=%0d grants_after=%0d exp id 0",
                     (got_q.size() > base) ? int'(got_q[base]) : -1, got_q.size() - base);
        end
        checks++;
        if (!queues_match()) begin
            errors++;
            $display("FAIL reset_mid_grants got=%0d exp=%0d grants", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [N_REQ-1:0] r;
        apply_reset();
        for (int c = 0; c < 440; c++) begin
            @(negedge clk1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            r = '0;
            if (c < 400)
                for (int i = 0; i < N_REQ; i++) r[i] = ($urandom_range(0, 7) == 0);
            bus.req = r;
        end
        checks++;
        if (!queues_match()) begin
            errors++;
            $display("FAIL random_grants got=%0d exp=%0d grants", got_q.size(), exp_q.size());
        end
    endtask
`else
    task automatic test_ack();
        bit seen;
        int lo_cnt;
        apply_reset();
        bus.ack_sync = 1'b0;
        @(negedge clk1);
        bus.req = 4'b0001;
        @(negedge clk1);
        bus.req = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk1);
            bus.req = '0;
            seen = bus.grant_vld;
        end
        checks++;
        if (!seen || bus.chan_id !== 2'd0) begin
            errors++;
            $display("FAIL ack_first_grant got seen=%0d id=%0d exp seen=1 id=0", seen, bus.chan_id);
        end
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk1);
            checks++;
            if (bus.chan_pulse !== 1'b1 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL ack_high cyc=%0d got pulse=%b busy=%b exp 1/1", c, bus.chan_pulse, bus.busy);
            end
        end
        bus.ack_sync = 1'b1;
        lo_cnt = 0;
        seen   = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk1);
            if (c == 3) bus.ack_sync = 1'b0;
            if (bus.grant_vld) begin
                seen = 1'b1;
            end else begin
                lo_cnt++;
                checks++;
                if (bus.chan_pulse !== 1'b0 || bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ack_low cyc=%0d got pulse=%b busy=%b exp 0/1", c, bus.chan_pulse, bus.busy);
                end
            end
        end
        checks++;
        if (!seen || lo_cnt != 4 + GAP_CYC || bus.chan_id !== 2'd1) begin
            errors++;
            $display("FAIL ack_gap got seen=%0d low=%0d id=%0d exp seen=1 low=%0d id=1",
                     seen, lo_cnt, bus.chan_id, 4 + GAP_CYC);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk1);
            checks++;
            if (bus.busy !== 1'b1 || bus.chan_pulse !== 1'b1) begin
                errors++;
                $display("FAIL ack_hold cyc=%0d got busy=%b pulse=%b exp 1/1", c, bus.busy, bus.chan_pulse);
            end
        end
    endtask
`endif

    initial begin
        bus.req = '0;
`ifdef FTS_SCHED_ACK_EN
        bus.ack_sync = 1'b0;
        test_ack();
`else
        test_reset();
        test_fairness();
        test_drop();
        test_collision();
        test_reset_mid();
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog got timeout exp completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
